// File: rtl/sub_result_normalize.sv
// Two-stage post-subtraction normalizer: per-lane sign/magnitude, leading-zero count, left normalize.
// Optional 2-entry output skid buffer (registered in_ready) enabled by NORM_OUT_SKID_EN.
module sub_result_normalize (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  cont,
  input  logic [1:0]  d,
  input  logic [55:0] diff,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [55:0] res,
  output logic [5:0]  lzc_hi,
  output logic [4:0]  lzc_lo,
  output logic        sign_hi,
  output logic        sign_lo,
  output logic        zero_hi,
  output logic        zero_lo,
  output logic [2:0]  cont_o,
  output logic [1:0]  d_o
);

  typedef enum logic [1:0] {MODE_WIDE = 2'd0, MODE_DUAL = 2'd1, MODE_INV = 2'd2} mode_t;
  localparam int WORD_W = 76;

  function automatic logic [5:0] lzc56(input logic [55:0] v);
    logic [5:0] n;
    logic       found;
    n = 6'd56;
    found = 1'b0;
    for (int i = 55; i >= 0; i--) begin
      if (!found && v[i]) begin
        n = 6'(55 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  mode_t              mode_s, s1_mode_r;
  logic               sign_hi_s, sign_lo_s, s1_sign_hi_r, s1_sign_lo_r;
  logic [55:0]        mag_s, s1_mag_r;
  logic [2:0]         s1_cont_r;
  logic [1:0]         s1_d_r;
  logic               s1_valid_r, s2_valid_r;
  logic [WORD_W-1:0]  word_s, s2_word_r, out_word_s;
  logic               s1_adv_s, s2_adv_s, accept_s;
  logic [5:0]         lzc_w_s;
  logic [4:0]         lzc_h_s, lzc_l_s;

  // Stage-1 input decode: lane split, sign and magnitude
  always_comb begin
    mode_s    = MODE_INV;
    sign_hi_s = 1'b0;
    sign_lo_s = 1'b0;
    mag_s     = 56'd0;
    case (cont)
      3'b000, 3'b010: begin
        mode_s    = MODE_WIDE;
        sign_hi_s = diff[55];
        mag_s     = diff[55] ? (56'd0 - diff) : diff;
      end
      3'b001: begin
        mode_s    = MODE_DUAL;
        sign_hi_s = diff[55];
        sign_lo_s = diff[23];
        mag_s     = {(diff[55] ? (24'd0 - diff[55:32]) : diff[55:32]), 8'd0,
                     (diff[23] ? (24'd0 - diff[23:0]) : diff[23:0])};
      end
      default: begin
        mode_s    = MODE_INV;
        sign_hi_s = 1'b0;
        sign_lo_s = 1'b0;
        mag_s     = 56'd0;
      end
    endcase
  end

  // Stage-2 compute: leading-zero counts and normalized lanes packed into one output word
  always_comb begin
    lzc_w_s = lzc56(s1_mag_r);
    lzc_h_s = lzc24(s1_mag_r[55:32]);
    lzc_l_s = lzc24(s1_mag_r[23:0]);
    word_s  = {56'd0, 6'd56, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, s1_cont_r, s1_d_r};
    case (s1_mode_r)
      MODE_WIDE: word_s = {s1_mag_r << lzc_w_s, lzc_w_s, 5'd0, s1_sign_hi_r, 1'b0,
                           (s1_mag_r == 56'd0), 1'b0, s1_cont_r, s1_d_r};
      MODE_DUAL: word_s = {s1_mag_r[55:32] << lzc_h_s, 8'd0, s1_mag_r[23:0] << lzc_l_s,
                           {1'b0, lzc_h_s}, lzc_l_s, s1_sign_hi_r, s1_sign_lo_r,
                           (s1_mag_r[55:32] == 24'd0), (s1_mag_r[23:0] == 24'd0),
                           s1_cont_r, s1_d_r};
      default:   word_s = {56'd0, 6'd56, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, s1_cont_r, s1_d_r};
    endcase
  end

  assign s1_adv_s = !s1_valid_r || s2_adv_s;
  assign accept_s = in_valid && in_ready;

  // Pipeline stage registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_mode_r    <= MODE_INV;
      s1_sign_hi_r <= 1'b0;
      s1_sign_lo_r <= 1'b0;
      s1_mag_r     <= 56'd0;
      s1_cont_r    <= 3'd0;
      s1_d_r       <= 2'd0;
      s2_valid_r   <= 1'b0;
      s2_word_r    <= '0;
    end else begin
      if (s1_adv_s) begin
        s1_valid_r <= accept_s;
        if (accept_s) begin
          s1_mode_r    <= mode_s;
          s1_sign_hi_r <= sign_hi_s;
          s1_sign_lo_r <= sign_lo_s;
          s1_mag_r     <= mag_s;
          s1_cont_r    <= cont;
          s1_d_r       <= d;
        end
      end
      if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          s2_word_r <= word_s;
        end
      end
    end
  end

`ifdef NORM_OUT_SKID_EN
  logic [1:0]        sk_cnt_r;
  logic [WORD_W-1:0] sk0_r, sk1_r;
  logic              direct_s, pop_s, push_s;

  // Skid control: stage 2 drains straight out only when the skid is empty, otherwise queues behind it
  always_comb begin
    direct_s = s2_valid_r && (sk_cnt_r == 2'd0) && out_ready;
    pop_s    = (sk_cnt_r != 2'd0) && out_ready;
    push_s   = s2_valid_r && !direct_s && ((sk_cnt_r != 2'd2) || pop_s);
    s2_adv_s = !s2_valid_r || direct_s || push_s;
  end

  assign in_ready   = (sk_cnt_r == 2'd0);
  assign out_valid  = s2_valid_r || (sk_cnt_r != 2'd0);
  assign out_word_s = (sk_cnt_r != 2'd0) ? sk0_r : s2_word_r;

  // Skid FIFO storage, sk0_r is the head
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sk_cnt_r <= 2'd0;
      sk0_r    <= '0;
      sk1_r    <= '0;
    end else begin
      if (pop_s) begin
        sk0_r <= sk1_r;
      end
      if (push_s) begin
        if ((sk_cnt_r - {1'b0, pop_s}) == 2'd0) begin
          sk0_r <= s2_word_r;
        end else begin
          sk1_r <= s2_word_r;
        end
      end
      sk_cnt_r <= sk_cnt_r - {1'b0, pop_s} + {1'b0, push_s};
    end
  end
`else
  assign s2_adv_s   = !s2_valid_r || out_ready;
  assign in_ready   = s1_adv_s;
  assign out_valid  = s2_valid_r;
  assign out_word_s = s2_word_r;
`endif

  assign {res, lzc_hi, lzc_lo, sign_hi, sign_lo, zero_hi, zero_lo, cont_o, d_o} = out_word_s;

endmodule
